store_buffer_align: RTL and testbench

- Store-side counterpart of the load data extractor. Takes sb/sh/sw requests from the MEM stage and converts each into a word-aligned address, lane-replicated write data and a byte strobe.
- Holds formatted stores in a small FIFO and drains them to the L1 data cache with a req/ack handshake.
- Flags misaligned or illegal stores instead of writing them.

---
 rtl/store_buffer_align.sv | 113 +++++++++++
 tb/tb_store_buffer_align.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_align.sv
// Store formatter and small in-order write buffer between the MEM stage and the L1 D-cache.
// Formats sb/sh/sw into word address, lane-replicated data and byte strobe; drops misaligned stores.
module store_buffer_align #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 2,
  parameter logic [2:0]  SW         = 3'b010,
  parameter logic [2:0]  SH         = 3'b001,
  parameter logic [2:0]  SB         = 3'b000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [2:0]                   s_type,
  input  logic [DATA_WIDTH-1:0]        st_address,
  input  logic [DATA_WIDTH-1:0]        st_data,
  output logic                         misalign,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic [DATA_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [3:0]                   mem_wstrb,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [3:0]            r_strb [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_misalign;

  logic [1:0]            w_off;
  logic                  w_legal;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_wstrb;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

  always_comb begin
    w_off   = st_address[1:0];
    w_wdata = st_data;
    w_wstrb = 4'b1111;
    w_legal = 1'b0;
    case (s_type)
      SB: begin
        w_wdata = {4{st_data[7:0]}};
        w_wstrb = 4'b0001 << w_off;
        w_legal = 1'b1;
      end
      SH: begin
        w_wdata = {2{st_data[15:0]}};
        w_wstrb = w_off[1] ? 4'b1100 : 4'b0011;
        w_legal = !w_off[0];
      end
      SW: begin
        w_legal = (w_off == 2'b00);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // st_ready depends on count only, so a full buffer never pushes even when popping.
  assign st_ready = (r_count != CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !empty && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_strb[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && !w_legal;
      if (w_push) begin
        r_addr[r_wr_ptr] <= {st_address[DATA_WIDTH-1:2], 2'b00};
        r_data[r_wr_ptr] <= w_wdata;
        r_strb[r_wr_ptr] <= w_wstrb;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign misalign  = r_misalign;
  assign mem_req   = !empty;
  assign count     = r_count;
  assign mem_addr  = empty ? '0 : r_addr[r_rd_ptr];
  assign mem_wdata = empty ? '0 : r_data[r_rd_ptr];
  assign mem_wstrb = empty ? '0 : r_strb[r_rd_ptr];

endmodule

// File: tb/tb_store_buffer_align.sv
// Bench for store_buffer_align: vector table, hand-written corner sequences, random run against a queue model.
module tb_store_buffer_align;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  s_type;
  logic [31:0] st_address;
  logic [31:0] st_data;
  logic        misalign;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        empty;
  logic [1:0]  count;

  int n_tests;
  int n_fail;

  // scoreboard entries: {addr, wdata, wstrb}
  logic [67:0] exp_q[$];

  store_buffer_align #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .s_type(s_type),
    .st_address(st_address), .st_data(st_data), .misalign(misalign),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .empty(empty), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid   = 1'b1;
    s_type     = t;
    st_address = a;
    st_data    = d;
  endtask

  task automatic idle();
    st_valid = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    check({name, ".req"}, {31'd0, mem_req}, 32'd1);
    check({name, ".addr"}, mem_addr, a);
    check({name, ".wdata"}, mem_wdata, d);
    check({name, ".wstrb"}, {28'd0, mem_wstrb}, {28'd0, s});
  endtask

  // Reference formatter from the store rules: {legal, addr, wdata, wstrb}.
  function automatic logic [68:0] model_fmt(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] d);
    int          off;
    logic        legal;
    logic [31:0] wd;
    logic [3:0]  sb;
    off   = int'(a % 4);
    legal = 1'b0;
    wd    = 32'd0;
    sb    = 4'd0;
    case (t)
      3'd0: begin legal = 1'b1; wd = d[7:0] * 32'h01010101; sb = 4'(1 << off); end
      3'd1: begin legal = (off % 2 == 0); wd = d[15:0] * 32'h00010001; sb = 4'(3 << off); end
      3'd2: begin legal = (off == 0); wd = d; sb = 4'hF; end
      default: legal = 1'b0;
    endcase
    return {legal, a - 32'(off), wd, sb};
  endfunction

  typedef struct packed {
    logic [2:0]  t;
    logic [31:0] addr;
    logic [31:0] data;
    logic        legal;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vec [10];

  initial begin
    logic [68:0] f;
    logic [67:0] head;
    bit          acc;
    bit          exp_mis;

    n_tests = 0;
    n_fail  = 0;
    vec[0] = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
    vec[1] = '{3'b000, 32'h0000_1000, 32'h1234_5678, 1'b1, 32'h0000_1000, 32'h7878_7878, 4'b0001};
    vec[2] = '{3'b001, 32'h0000_2002, 32'h1234_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vec[3] = '{3'b001, 32'h0000_2000, 32'hFFFF_0102, 1'b1, 32'h0000_2000, 32'h0102_0102, 4'b0011};
    vec[4] = '{3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
    vec[5] = '{3'b010, 32'h0000_3001, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 4'b0000};
    vec[6] = '{3'b001, 32'h0000_3003, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 4'b0000};
    vec[7] = '{3'b011, 32'h0000_3000, 32'h3333_3333, 1'b0, 32'h0, 32'h0, 4'b0000};
    vec[8] = '{3'b010, 32'h0000_3002, 32'h4444_4444, 1'b0, 32'h0, 32'h0, 4'b0000};
    vec[9] = '{3'b100, 32'h0000_3004, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 4'b0000};

    rst_n = 1'b0; st_valid = 1'b0; s_type = 3'd0; st_address = 32'd0; st_data = 32'd0; mem_ack = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    check("rst.count", {30'd0, count}, 32'd0);
    check("rst.empty", {31'd0, empty}, 32'd1);
    check("rst.req", {31'd0, mem_req}, 32'd0);
    check("rst.misalign", {31'd0, misalign}, 32'd0);
    check("rst.ready", {31'd0, st_ready}, 32'd1);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.wstrb", {28'd0, mem_wstrb}, 32'd0);

    // single stores into an empty buffer
    for (int i = 0; i < 10; i++) begin
      drive_store(vec[i].t, vec[i].addr, vec[i].data);
      tick();
      idle();
      if (vec[i].legal) begin
        check_head($sformatf("vec%0d", i), vec[i].e_addr, vec[i].e_wdata, vec[i].e_wstrb);
        check($sformatf("vec%0d.misalign", i), {31'd0, misalign}, 32'd0);
        check($sformatf("vec%0d.count", i), {30'd0, count}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check($sformatf("vec%0d.empty", i), {31'd0, empty}, 32'd1);
        check($sformatf("vec%0d.req_off", i), {31'd0, mem_req}, 32'd0);
      end else begin
        check($sformatf("vec%0d.misalign", i), {31'd0, misalign}, 32'd1);
        check($sformatf("vec%0d.count", i), {30'd0, count}, 32'd0);
        check($sformatf("vec%0d.req", i), {31'd0, mem_req}, 32'd0);
        check($sformatf("vec%0d.ready", i), {31'd0, st_ready}, 32'd1);
        tick();
        check($sformatf("vec%0d.mis_pulse", i), {31'd0, misalign}, 32'd0);
      end
    end

    // back-to-back illegal stores hold misalign high
    drive_store(3'b010, 32'h0000_5001, 32'h0);
    tick();
    check("b2b.mis1", {31'd0, misalign}, 32'd1);
    drive_store(3'b001, 32'h0000_5001, 32'h0);
    tick();
    check("b2b.mis2", {31'd0, misalign}, 32'd1);
    idle();
    tick();
    check("b2b.mis3", {31'd0, misalign}, 32'd0);

    // fill to full with no ack, then drain in order
    drive_store(3'b001, 32'h0000_2002, 32'h1234_BEEF);
    tick();
    drive_store(3'b010, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    idle();
    check("full.count", {30'd0, count}, 32'd2);
    check("full.ready", {31'd0, st_ready}, 32'd0);
    check_head("full.h0", 32'h2000, 32'hBEEF_BEEF, 4'b1100);
    tick();
    check_head("full.stall", 32'h2000, 32'hBEEF_BEEF, 4'b1100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_head("full.h1", 32'h2004, 32'hCAFE_F00D, 4'b1111);
    check("full.count1", {30'd0, count}, 32'd1);

    // full + ack + valid held: first edge pops only, next edge pushes and pops
    drive_store(3'b010, 32'h0000_6000, 32'hAAAA_0000);
    tick();
    check("fp.count2", {30'd0, count}, 32'd2);
    drive_store(3'b010, 32'h0000_6004, 32'hBBBB_0000);
    mem_ack = 1'b1;
    tick();
    check("fp.count_pop", {30'd0, count}, 32'd1);
    check("fp.head_a", mem_addr, 32'h6000);
    tick();
    check("fp.count_pp", {30'd0, count}, 32'd1);
    check("fp.head_b", mem_addr, 32'h6004);
    idle();
    tick();
    mem_ack = 1'b0;
    check("fp.empty", {31'd0, empty}, 32'd1);

    // ack while empty is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ackempty.count", {30'd0, count}, 32'd0);

    // random run against the queue model
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [2:0] t;
        t = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        drive_store(t, $urandom, $urandom);
      end else begin
        idle();
      end
      mem_ack = ($urandom_range(0, 2) == 0);

      check("rnd.ready", {31'd0, st_ready}, {31'd0, exp_q.size() != DEPTH});
      check("rnd.count", {30'd0, count}, 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check_head("rnd.head", head[67:36], head[35:4], head[3:0]);
      end else begin
        check("rnd.req_off", {31'd0, mem_req}, 32'd0);
      end

      f       = model_fmt(s_type, st_address, st_data);
      acc     = st_valid && (exp_q.size() != DEPTH);
      exp_mis = acc && !f[68];
      if (mem_ack && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc && f[68]) exp_q.push_back(f[67:0]);
      tick();
      check("rnd.misalign", {31'd0, misalign}, {31'd0, exp_mis});
    end
    idle();
    mem_ack = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
    end
    mem_ack = 1'b0;
    check("rnd.drained", {31'd0, empty}, 32'd1);

    // asynchronous reset mid-drain
    drive_store(3'b000, 32'h0000_7001, 32'h0000_0011);
    tick();
    drive_store(3'b000, 32'h0000_7002, 32'h0000_0022);
    tick();
    idle();
    check("ar.count_pre", {30'd0, count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.count", {30'd0, count}, 32'd0);
    check("ar.req", {31'd0, mem_req}, 32'd0);
    check("ar.misalign", {31'd0, misalign}, 32'd0);
    check("ar.addr", mem_addr, 32'd0);
    #1;
    rst_n = 1'b1;
    drive_store(3'b010, 32'h0000_8000, 32'h0BAD_F00D);
    tick();
    idle();
    check_head("ar.fresh", 32'h8000, 32'h0BAD_F00D, 4'b1111);
    check("ar.count1", {30'd0, count}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ar.empty", {31'd0, empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
